// File: rtl/mult_pkg.sv
// Shared definitions for the 8x8 multiply sequencer: state encoding, shifter codes
// and the per-step nibble/shift schedule.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LSB       = 3'd1,
        MID       = 3'd2,
        MSB       = 3'd3,
        CALC_DONE = 3'd4,
        ERR       = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SHIFT_NONE = 2'b00,
        SHIFT_4    = 2'b01,
        SHIFT_8    = 2'b10
    } shift_e;

    typedef struct packed {
        logic   a_hi;
        logic   b_hi;
        shift_e shift;
    } step_sched_t;

    // Step order: lo*lo, hi*lo, lo*hi, hi*hi.
    function automatic step_sched_t step_schedule(input logic [1:0] step);
        step_sched_t s;
        s.a_hi = step[0];
        s.b_hi = step[1];
        case (step)
            2'd0:    s.shift = SHIFT_NONE;
            2'd3:    s.shift = SHIFT_8;
            default: s.shift = SHIFT_4;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Signal bundle between the multiply sequencer and its environment (requester,
// external 4x4 multiplier and shifter).
interface mult_sequencer_if;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [1:0]  shift_cntrl;
    logic [15:0] shift_out;
    logic [15:0] product8x8_out;
    logic        done_flag;
    logic        busy;
    logic [2:0]  state_out;

    modport master (
        output start, dataa, datab, shift_out,
        input  a_nib, b_nib, shift_cntrl, product8x8_out, done_flag, busy, state_out
    );

    modport slave (
        input  start, dataa, datab, shift_out,
        output a_nib, b_nib, shift_cntrl, product8x8_out, done_flag, busy, state_out
    );
endinterface

// File: rtl/mult_step_counter.sv
// Two-bit step counter: synchronous clear has priority over enable; async reset.
module mult_step_counter (
    input  logic       clk,
    input  logic       reset_a,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [1:0] step_o
);
    logic [1:0] step_q, step_d;

    // NOTE: next-state gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        step_d = step_q;
        if (clr_i) begin
            step_d = 2'd0;
        end else if (en_i) begin
            step_d = step_q + 2'd1;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            step_q <= 2'd0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step_o = step_q;
endmodule

// File: rtl/mult_sequencer.sv
// Sequences an 8x8 multiply through an external 4x4 multiplier and shifter in four steps.
// Define MULT_SEQ_ERR_EN to trap a start request while busy into the ERR state.
module mult_sequencer
    import mult_pkg::*;
(
    input logic             clk,
    input logic             reset_a,
    mult_sequencer_if.slave bus
);
    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  step;
    logic        busy;
    logic        accept;
    step_sched_t sched;

    assign busy   = (state_q == LSB) || (state_q == MID) || (state_q == MSB);
    assign accept = bus.start && !busy;

    mult_step_counter u_step (
        .clk     (clk),
        .reset_a (reset_a),
        .clr_i   (accept),
        .en_i    (busy),
        .step_o  (step)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = busy ? acc_q + bus.shift_out : acc_q;

        case (state_q)
            LSB:     state_d = MID;
            MID:     if (step == 2'd2) state_d = MSB;
            MSB:     state_d = CALC_DONE;
`ifdef MULT_SEQ_ERR_EN
            ERR:     state_d = ERR;
`endif
            default: state_d = IDLE;
        endcase

`ifdef MULT_SEQ_ERR_EN
        // A colliding start abandons the operation and leaves the partial sum untouched.
        if (bus.start && busy) begin
            state_d = ERR;
            acc_d   = acc_q;
        end
`endif

        if (accept) begin
            state_d = LSB;
            a_d     = bus.dataa;
            b_d     = bus.datab;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign sched = step_schedule(step);

    assign bus.a_nib          = busy ? (sched.a_hi ? a_q[7:4] : a_q[3:0]) : 4'h0;
    assign bus.b_nib          = busy ? (sched.b_hi ? b_q[7:4] : b_q[3:0]) : 4'h0;
    assign bus.shift_cntrl    = busy ? sched.shift : SHIFT_NONE;
    assign bus.product8x8_out = acc_q;
    assign bus.done_flag      = (state_q == CALC_DONE);
    assign bus.busy           = busy;
    assign bus.state_out      = state_q;
endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_a  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request to begin a multiply; sampled every rising edge.
REQ-004 SHALL have port dataa  input  8  multiplicand; captured only when start is accepted.
REQ-005 SHALL have port datab  input  8  multiplier; captured only when start is accepted.
REQ-006 SHALL have port a_nib  output  4  nibble of captured dataa driven to the external 4x4 multiplier.
REQ-007 SHALL have port b_nib  output  4  nibble of captured datab driven to the external 4x4 multiplier.
REQ-008 SHALL have port shift_cntrl  output  2  shift code to the downstream shifter: 00 none, 01 left 4, 10 left 8.
REQ-009 SHALL have port shift_out  input  16  shifted partial product returned combinationally in the same cycle.
REQ-010 SHALL have port product8x8_out  output  16  accumulated product.
REQ-011 SHALL have port done_flag  output  1  high for exactly one cycle when the product is complete.
REQ-012 SHALL have port busy  output  1  high in states LSB, MID and MSB.
REQ-013 SHALL have port state_out  output  3  current state encoding for debug.

Function
REQ-014 SHALL implement the states IDLE, LSB, MID, MSB, CALC_DONE and ERR, with a 2-bit step counter.
REQ-015 SHALL accept start in IDLE, CALC_DONE or ERR as follows:
- capture dataa and datab
- clear the accumulator and the step counter to 0
- go to LSB.
REQ-016 SHALL use this step schedule (step 0 in LSB, steps 1-2 in MID, step 3 in MSB), with the step counter incrementing each busy cycle:
- step 0: a_nib=a[3:0], b_nib=b[3:0], shift 00
- step 1: a_nib=a[7:4], b_nib=b[3:0], shift 01
- step 2: a_nib=a[3:0], b_nib=b[7:4], shift 01
- step 3: a_nib=a[7:4], b_nib=b[7:4], shift 10.
REQ-017 SHALL add shift_out into the accumulator at every rising edge while busy; the addition is 16-bit and wraps modulo 2^16.
REQ-018 SHALL take these transitions:
- LSB goes to MID
- MID goes to MSB after step 2
- MSB goes to CALC_DONE
- CALC_DONE goes to IDLE unless start is high.
REQ-019 SHALL assert done_flag exactly while in CALC_DONE, which is the 5th cycle after the edge that accepted start.
REQ-020 SHALL hold product8x8_out stable from CALC_DONE until the next accepted start; it is cleared at that accept.
REQ-021 SHALL drive a_nib=0, b_nib=0 and shift_cntrl=00 in IDLE, CALC_DONE and ERR.
REQ-022 SHALL handle start while busy per REQ-030.
REQ-023 SHALL, in ERR, hold until start, then restart per REQ-015.

Reset
REQ-024 SHALL, on reset_a assertion, immediately force:
- state IDLE, step 0, accumulator 0, captured operands 0
- done_flag=0, busy=0.
REQ-025 SHALL let reset_a abort an in-flight multiply with no residual done_flag.
REQ-026 SHALL, on reset release, honour start from the first rising edge after deassertion.

Configuration
REQ-027 SHALL compile the error-detection feature only when macro MULT_SEQ_ERR_EN is defined.
REQ-028 SHALL, with MULT_SEQ_ERR_EN defined, go to ERR with accumulator unchanged when start is high in LSB, MID or MSB.
REQ-029 SHALL, without MULT_SEQ_ERR_EN, remove the ERR state and ignore start while busy; the operation completes normally.
REQ-030 SHALL implement REQ-022 according to REQ-028 or REQ-029 depending on the macro.

Structure
REQ-031 SHALL place these definitions in shared package mult_pkg:
- state encoding constants: IDLE=0, LSB=1, MID=2, MSB=3, CALC_DONE=4, ERR=5
- shift codes SHIFT_NONE=00, SHIFT_4=01, SHIFT_8=10.
REQ-032 SHALL instantiate one sub-module, mult_step_counter: 2-bit counter with synchronous clear and enable, async reset_a.
REQ-033 SHALL contain neither the 4x4 multiplier nor the shifter; both remain external.

Verification
REQ-034 SHALL cover: dataa=12, datab=10, start pulse -> done_flag in cycle 5, product8x8_out=16'h0078.
REQ-035 SHALL cover: dataa=8'hFF, datab=8'hFF -> product8x8_out=16'hFE01; shift_cntrl sequence 00, 01, 01, 10.
REQ-036 SHALL cover: start again in step 2 with macro on -> state_out=5 and done_flag never asserts; then start with 8'h03 x 8'h05 -> product 16'h000F.
REQ-037 SHALL cover: the same stimulus as REQ-036 with macro off -> original product completes; the second start is ignored.
REQ-038 SHALL cover: reset_a pulse during MID -> all outputs 0 immediately; next start with 8'h80 x 8'h02 -> 16'h0100.
REQ-039 SHALL cover: start held high in CALC_DONE with 8'h01 x 8'h01 -> back-to-back operation, second product 16'h0001.
